router_1xn: RTL and testbench

- Parametrised successor to the 1x3 packet router.
- Accepts byte-serial packets on one input port and routes each packet to one of NUM_PORTS output FIFOs, selected by the address field of the header.
- Checks even-XOR parity and payload length, and applies per-port flow control and a read-timeout soft reset.
- Sits between the packet source and NUM_PORTS independent consumers.

---
 rtl/router_1xn.sv | 216 +++++++++++++++++++++
 tb/tb_router_1xn.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_1xn.sv
// router_1xn: byte-serial 1-to-N packet router. Each packet is steered by its
// header address into one of NUM_PORTS output FIFOs. The router checks XOR
// parity and payload length, and flushes a channel that goes unread too long.
module router_1xn #(
  parameter int unsigned DW        = 8,
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TIMEOUT   = 30
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    pkt_valid,
  input  logic [DW-1:0]           data_in,
  input  logic [NUM_PORTS-1:0]    read_enb,
  output logic [NUM_PORTS*DW-1:0] data_out,
  output logic [NUM_PORTS-1:0]    vld_out,
  output logic                    busy,
  output logic                    err,
  output logic                    len_err
);

  localparam int unsigned AW  = $clog2(NUM_PORTS);
  localparam int unsigned CW  = DW - AW;
  localparam int unsigned NP2 = 1 << AW;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWaitEmpty, StLoad, StCheck, StDrop} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] dest_q, dest_d;
  logic [DW-1:0] hdr_q, hdr_d;
  logic [DW-1:0] parity_q, parity_d;
  logic [DW-1:0] rx_parity_q, rx_parity_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_q, len_d;
  logic          err_q, err_d;
  logic          len_err_q, len_err_d;

  logic [NUM_PORTS-1:0] empty, full, flush, wr_en;
  logic [NP2-1:0]       empty_x, full_x, flush_x;
  logic                 wr_any;
  logic [AW-1:0]        wr_sel;
  logic [DW-1:0]        wr_data;
  logic [AW-1:0]        hdr_addr;
  logic                 hdr_bad;

  assign hdr_addr = data_in[AW-1:0];
  assign hdr_bad  = 32'(hdr_addr) >= NUM_PORTS;

  // Pad the per-channel status to a power of two so any address can index it safely.
  always_comb begin
    empty_x = '1;
    full_x  = '0;
    flush_x = '0;
    empty_x[NUM_PORTS-1:0] = empty;
    full_x[NUM_PORTS-1:0]  = full;
    flush_x[NUM_PORTS-1:0] = flush;
  end

  // Decode the single FIFO write port into per-channel enables.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      wr_en[k] = wr_any && (wr_sel == AW'(k));
    end
  end

  // Packet FSM: next state, FIFO write request, checker updates and busy.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    hdr_d       = hdr_q;
    parity_d    = parity_q;
    rx_parity_d = rx_parity_q;
    count_d     = count_q;
    len_d       = len_q;
    err_d       = err_q;
    len_err_d   = len_err_q;
    wr_any      = 1'b0;
    wr_sel      = dest_q;
    wr_data     = data_in;
    busy        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pkt_valid) begin
          dest_d = hdr_addr;
          hdr_d  = data_in;
          if (hdr_bad) begin
            state_d = StDrop;
          end else if (empty_x[hdr_addr]) begin
            wr_any    = 1'b1;
            wr_sel    = hdr_addr;
            err_d     = 1'b0;
            len_err_d = 1'b0;
            parity_d  = data_in;
            count_d   = '0;
            len_d     = data_in[DW-1:AW];
            state_d   = StLoad;
          end else begin
            state_d = StWaitEmpty;
          end
        end
      end
      StWaitEmpty: begin
        busy = 1'b1;
        if (flush_x[dest_q]) begin
          state_d = StDrop;
        end else if (empty_x[dest_q]) begin
          wr_any    = 1'b1;
          wr_data   = hdr_q;
          err_d     = 1'b0;
          len_err_d = 1'b0;
          parity_d  = hdr_q;
          count_d   = '0;
          len_d     = hdr_q[DW-1:AW];
          state_d   = StLoad;
        end
      end
      StLoad: begin
        busy = full_x[dest_q];
        if (!full_x[dest_q]) begin
          wr_any = 1'b1;
          if (pkt_valid) begin
            parity_d = parity_q ^ data_in;
            if (count_q != '1) count_d = count_q + 1'b1;
          end else begin
            rx_parity_d = data_in;
            state_d     = StCheck;
          end
        end
        // A flush abandons the packet; if its last byte was just taken there is nothing to drop.
        if (flush_x[dest_q]) begin
          state_d = (!full_x[dest_q] && !pkt_valid) ? StIdle : StDrop;
        end
      end
      StCheck: begin
        busy      = 1'b1;
        err_d     = parity_q != rx_parity_q;
        len_err_d = count_q != len_q;
        state_d   = StIdle;
      end
      StDrop: begin
        if (!pkt_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and checker registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StIdle;
      dest_q      <= '0;
      hdr_q       <= '0;
      parity_q    <= '0;
      rx_parity_q <= '0;
      count_q     <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      hdr_q       <= hdr_d;
      parity_q    <= parity_d;
      rx_parity_q <= rx_parity_d;
      count_q     <= count_d;
      len_q       <= len_d;
      err_q       <= err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign err     = err_q;
  assign len_err = len_err_q;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : gen_ch
    logic [DW-1:0] mem [DEPTH];
    logic [PW:0]   wptr_q, rptr_q;
    logic [DW-1:0] dout_q;
    logic [TW-1:0] timer_q;
    logic          rd_en, idle;

    assign empty[k] = wptr_q == rptr_q;
    assign full[k]  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign rd_en    = read_enb[k] & ~empty[k];
    assign idle     = ~empty[k] & ~read_enb[k];
    // The edge that closes the TIMEOUT-th consecutive unread cycle is the flush edge.
    assign flush[k] = idle && (timer_q == TW'(TIMEOUT - 1));
    assign vld_out[k]           = ~empty[k];
    assign data_out[k*DW +: DW] = dout_q;

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
      if (wr_en[k]) mem[wptr_q[PW-1:0]] <= wr_data;
    end

    // Pointers, read register and idle timer; a flush acts as a local reset.
    always_ff @(posedge clock) begin
      if (!resetn || flush[k]) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        dout_q  <= '0;
        timer_q <= '0;
      end else begin
        if (wr_en[k]) wptr_q <= wptr_q + 1'b1;
        if (rd_en) begin
          dout_q <= mem[rptr_q[PW-1:0]];
          rptr_q <= rptr_q + 1'b1;
        end
        timer_q <= idle ? timer_q + 1'b1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed and randomized packets against a queue-based
// scoreboard of expected per-channel byte streams and packet-level error flags.
module tb_router_1xn;

  localparam int DW      = 8;
  localparam int NP      = 3;
  localparam int AW      = 2;
  localparam int TIMEOUT = 30;
  localparam int LMAX    = (1 << (DW - AW)) - 1;

  logic             clock = 1'b0;
  logic             resetn;
  logic             pkt_valid;
  logic [DW-1:0]    data_in;
  logic [NP-1:0]    read_enb;
  logic [NP*DW-1:0] data_out;
  logic [NP-1:0]    vld_out;
  logic             busy;
  logic             err;
  logic             len_err;

  int vectors = 0;
  int fails   = 0;

  logic [DW-1:0] expq [NP][$];
  int            rd_cnt [NP];
  int            idle_cnt [NP];
  logic [NP-1:0] mon_fire, mon_flush;
  bit            mon_rst;

  int accepted;
  bit busy_seen, vld_seen;
  bit exp_err, exp_len_err;
  int vld_cycles, busy_at, rd_base;
  bit rand_done;

  router_1xn #(
    .DW       (DW),
    .NUM_PORTS(NP),
    .DEPTH    (16),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .pkt_valid(pkt_valid),
    .data_in  (data_in),
    .read_enb (read_enb),
    .data_out (data_out),
    .vld_out  (vld_out),
    .busy     (busy),
    .err      (err),
    .len_err  (len_err)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read scoreboard plus the idle-timeout rule, sampled 1 time unit after each edge.
  always @(posedge clock) begin
    mon_rst = !resetn;
    for (int k = 0; k < NP; k++) begin
      mon_fire[k]  = read_enb[k] & vld_out[k];
      mon_flush[k] = 1'b0;
      if (mon_rst || !(vld_out[k] && !read_enb[k])) begin
        idle_cnt[k] = 0;
      end else begin
        idle_cnt[k]++;
        if (idle_cnt[k] == TIMEOUT) begin
          mon_flush[k] = 1'b1;
          idle_cnt[k]  = 0;
        end
      end
    end
    #1;
    if (!mon_rst) begin
      for (int k = 0; k < NP; k++) begin
        if (mon_flush[k]) begin
          chk($sformatf("flush%0d_vld", k), vld_out[k], 0);
          chk($sformatf("flush%0d_data", k), data_out[k*DW +: DW], 0);
          expq[k].delete();
        end else if (mon_fire[k]) begin
          if (expq[k].size() == 0) begin
            chk($sformatf("unexpected_read%0d", k), 1, 0);
          end else begin
            chk($sformatf("data_out%0d", k), data_out[k*DW +: DW], expq[k].pop_front());
          end
          rd_cnt[k]++;
        end
      end
    end
  end

  // Present one byte and hold it until the router takes it (busy low at the edge).
  task automatic send_byte(input logic v, input logic [DW-1:0] b);
    int guard = 0;
    pkt_valid = v;
    data_in   = b;
    while (busy === 1'b1 && guard < 300) begin
      busy_seen = 1'b1;
      @(negedge clock);
      guard++;
    end
    if (guard >= 300) chk("busy_stuck", busy, 0);
    @(negedge clock);
    vld_seen = vld_seen | (|vld_out);
    accepted++;
  endtask

  // Build a packet, record its expected bytes and flags, then send it.
  task automatic send_pkt(input int addr, input int len_f, input int npay, input bit corrupt,
                          input bit chk_clr);
    logic [DW-1:0] bytes [$];
    logic [DW-1:0] hdr, par, b;
    int            cnt;
    hdr = DW'((len_f << AW) | addr);
    par = hdr;
    for (int i = 0; i < npay; i++) begin
      b = DW'($urandom);
      bytes.push_back(b);
      par = par ^ b;
    end
    if (corrupt) par = par ^ 8'h01;
    if (addr < NP) begin
      expq[addr].push_back(hdr);
      foreach (bytes[i]) expq[addr].push_back(bytes[i]);
      expq[addr].push_back(par);
      cnt         = (npay > LMAX) ? LMAX : npay;
      exp_err     = corrupt;
      exp_len_err = cnt != len_f;
    end
    send_byte(1'b1, hdr);
    if (chk_clr) begin
      chk("hdr_clears_err", err, 0);
      chk("hdr_clears_len_err", len_err, 0);
    end
    foreach (bytes[i]) send_byte(1'b1, bytes[i]);
    send_byte(1'b0, par);
  endtask

  task automatic drain(input int k);
    int guard = 0;
    while ((expq[k].size() != 0 || vld_out[k] === 1'b1) && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    chk($sformatf("drain%0d_vld", k), vld_out[k], 0);
    chk($sformatf("drain%0d_left", k), expq[k].size(), 0);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_len_err"}, len_err, exp_len_err);
  endtask

  initial begin
    resetn    = 1'b0;
    pkt_valid = 1'b0;
    data_in   = '0;
    read_enb  = '0;
    repeat (3) @(negedge clock);
    chk("rst_vld_out", vld_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_len_err", len_err, 0);
    resetn = 1'b1;
    @(negedge clock);

    // 14-byte payload to channel 1, reader enabled two cycles after the header lands.
    rd_base = rd_cnt[1];
    fork
      send_pkt(1, 14, 14, 1'b0, 1'b1);
      begin
        @(negedge clock);
        repeat (2) @(negedge clock);
        read_enb[1] = 1'b1;
      end
    join
    @(negedge clock);
    chk_flags("p1");
    drain(1);
    chk("p1_bytes_read", rd_cnt[1] - rd_base, 16);
    read_enb = '0;

    // 20-byte payload to channel 2 with no reader: busy must rise at 16 stored bytes.
    accepted = 0;
    busy_at  = -1;
    rd_base  = rd_cnt[2];
    fork
      send_pkt(2, 20, 20, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 60; i++) begin
          @(negedge clock);
          #1;
          if (busy === 1'b1) begin
            busy_at = accepted;
            break;
          end
        end
        read_enb[2] = 1'b1;
      end
    join
    chk("p2_busy_at_full", busy_at, 16);
    @(negedge clock);
    chk_flags("p2");
    drain(2);
    chk("p2_bytes_read", rd_cnt[2] - rd_base, 22);
    chk("p2_busy_released", busy, 0);

    // Corrupted parity to channel 0; err appears one cycle after the parity byte.
    read_enb = '1;
    send_pkt(0, 6, 6, 1'b1, 1'b1);
    chk("p3_err_not_yet", err, 0);
    @(negedge clock);
    chk_flags("p3");
    drain(0);
    chk("p3_err_held", err, 1);
    send_pkt(0, 3, 3, 1'b0, 1'b1);
    @(negedge clock);
    chk_flags("p3b");
    drain(0);

    // Header says 5, seven payload bytes follow.
    send_pkt(1, 5, 7, 1'b0, 1'b1);
    @(negedge clock);
    chk_flags("p4");
    drain(1);

    // Unroutable address: dropped silently, flags untouched, then normal routing.
    busy_seen = 1'b0;
    vld_seen  = 1'b0;
    send_pkt(3, 4, 4, 1'b0, 1'b0);
    @(negedge clock);
    chk("p5_busy_seen", busy_seen, 0);
    chk("p5_vld_seen", vld_seen, 0);
    chk("p5_vld_out", vld_out, 0);
    chk("p5_err_kept", err, 0);
    chk("p5_len_err_kept", len_err, 1);
    send_pkt(0, 3, 3, 1'b0, 1'b1);
    @(negedge clock);
    chk_flags("p5b");
    drain(0);

    // Channel 0 left unread: flushed after TIMEOUT cycles of valid data.
    read_enb   = '0;
    vld_cycles = 0;
    fork
      send_pkt(0, 2, 2, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clock);
          #1;
          if (vld_out[0] === 1'b1) vld_cycles++;
          else if (vld_cycles > 0) break;
        end
      end
    join
    chk("p6_vld_cycles", vld_cycles, TIMEOUT);
    chk("p6_vld_out", vld_out[0], 0);
    chk("p6_data_out", data_out[DW-1:0], 0);
    chk_flags("p6");
    read_enb = '1;
    send_pkt(0, 4, 4, 1'b0, 1'b1);
    @(negedge clock);
    chk_flags("p6b");
    drain(0);

    // Reset in the middle of a packet after a parity error.
    send_pkt(1, 4, 4, 1'b1, 1'b1);
    @(negedge clock);
    chk_flags("p7");
    drain(1);
    read_enb = '0;
    send_byte(1'b1, 8'h25);
    for (int i = 0; i < 3; i++) send_byte(1'b1, DW'($urandom));
    chk("p7_vld_before_rst", vld_out[1], 1);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_vld_out", vld_out, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_len_err", len_err, 0);
    for (int k = 0; k < NP; k++) expq[k].delete();
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    read_enb  = '1;
    @(negedge clock);
    send_pkt(1, 3, 3, 1'b0, 1'b1);
    @(negedge clock);
    chk_flags("p7b");
    drain(1);

    // Random packets with a random reader on every channel.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          int a, np, lf;
          bit cr;
          a  = $urandom_range(0, NP - 1);
          np = $urandom_range(0, 20);
          lf = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : np;
          cr = $urandom_range(0, 3) == 0;
          send_pkt(a, lf, np, cr, 1'b0);
          @(negedge clock);
          chk_flags($sformatf("rnd%0d", n));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          read_enb = NP'($urandom) | NP'($urandom);
          @(negedge clock);
        end
      end
    join
    read_enb = '1;
    for (int k = 0; k < NP; k++) drain(k);
    chk("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
